l2_write_buffer: RTL and testbench

//  Write buffer for evicted cache lines. Sits between the L1 cache's l2_* port and the
//  L2/physical-memory port. Absorbs L1 write-backs in 1 cycle and forwards buffered lines on

---
 rtl/l2_write_buffer.sv | 189 ++++++++++++++++++
 tb/tb_l2_write_buffer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_write_buffer.sv
// l2_write_buffer: circular FIFO of evicted L1 lines with read-hit forwarding and background drain.
// Optional in-place write coalescing is enabled by defining L2_WB_COALESCE_EN.
module l2_write_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  l2_address,
    input  logic         l2_read,
    input  logic         l2_write,
    input  logic [127:0] l2_wdata,
    output logic         l2_mem_resp,
    output logic [127:0] l2_rdata,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata
);
    localparam int unsigned   PW       = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RD_MEM = 2'd1;
    localparam logic [1:0] WR_MEM = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]     state;
    logic [DEPTH-1:0] valid;
    logic [11:0]    tag_q  [DEPTH];
    logic [127:0]   data_q [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [PW:0]    count;

    logic [11:0]    req_tag;
    logic           rd_req;
    logic           wr_req;
    logic           start_drain;
    logic           deq;
    logic           rd_hit;
    logic [PW-1:0]  rd_idx;
    logic [PW-1:0]  scan_idx;
    logic           do_coal;
    logic           do_enq;
    logic           coal_head;
    logic [PW-1:0]  wr_idx;
    logic           unused_addr_bits;

    assign req_tag          = l2_address[15:4];
    assign unused_addr_bits = ^l2_address[3:0];

    // Nothing is accepted while the previous response is still on the wire; read wins over write.
    assign rd_req = l2_read && !l2_mem_resp;
    assign wr_req = l2_write && !l2_read && !l2_mem_resp;
    // Holding off the drain during a response cycle lets a follow-up read hit before the line leaves.
    assign start_drain = (state == IDLE) && (count != '0) && !l2_read && !l2_mem_resp;
    assign deq         = (state == WR_MEM) && pmem_resp;

    // Scan oldest to youngest so the last match is the youngest entry.
    always_comb begin
        rd_hit   = 1'b0;
        rd_idx   = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = head + PW'(i);
            if (valid[scan_idx] && (tag_q[scan_idx] == req_tag)) begin
                rd_hit = 1'b1;
                rd_idx = scan_idx;
            end
        end
    end

`ifdef L2_WB_COALESCE_EN
    logic          co_hit;
    logic [PW-1:0] co_idx;
    logic [PW-1:0] co_scan;

    // The head line cannot be rewritten once its memory write is in flight.
    always_comb begin
        co_hit  = 1'b0;
        co_idx  = '0;
        co_scan = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            co_scan = head + PW'(i);
            if (valid[co_scan] && (tag_q[co_scan] == req_tag) &&
                !((state == WR_MEM) && (co_scan == head))) begin
                co_hit = 1'b1;
                co_idx = co_scan;
            end
        end
    end

    assign do_coal = wr_req && co_hit;
    assign wr_idx  = do_coal ? co_idx : tail;
`else
    assign do_coal = 1'b0;
    assign wr_idx  = tail;
`endif

    assign do_enq    = wr_req && !do_coal && (count != CNT_FULL);
    assign coal_head = do_coal && (wr_idx == head);

    always_ff @(posedge clk) begin
        if (do_enq) begin
            tag_q[tail] <= req_tag;
        end
        if (do_enq || do_coal) begin
            data_q[wr_idx] <= l2_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            valid        <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            l2_mem_resp  <= 1'b0;
            l2_rdata     <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            l2_mem_resp <= 1'b0;
            if (do_enq || do_coal) begin
                l2_mem_resp <= 1'b1;
            end

            if (deq) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_ONE;
            end
            if (do_enq) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_ONE;
            end
            if (do_enq && !deq) begin
                count <= count + CNT_ONE;
            end else if (!do_enq && deq) begin
                count <= count - CNT_ONE;
            end

            case (state)
                IDLE: begin
                    if (rd_req) begin
                        if (rd_hit) begin
                            l2_mem_resp <= 1'b1;
                            l2_rdata    <= data_q[rd_idx];
                        end else begin
                            state        <= RD_MEM;
                            pmem_read    <= 1'b1;
                            pmem_address <= {req_tag, 4'h0};
                        end
                    end else if (start_drain) begin
                        // A write coalescing into the head on this same edge supplies the drained data.
                        state        <= WR_MEM;
                        pmem_write   <= 1'b1;
                        pmem_address <= {tag_q[head], 4'h0};
                        pmem_wdata   <= coal_head ? l2_wdata : data_q[head];
                    end
                end
                RD_MEM: begin
                    if (pmem_resp) begin
                        pmem_read   <= 1'b0;
                        l2_rdata    <= pmem_rdata;
                        l2_mem_resp <= 1'b1;
                        state       <= RESP;
                    end
                end
                WR_MEM: begin
                    if (pmem_resp) begin
                        pmem_write <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_write_buffer.sv
// tb_l2_write_buffer: scoreboard bench; the reference treats buffer+memory as one coherent line store.
// Coalescing expectations follow L2_WB_COALESCE_EN when the bench is built with it.
module tb_l2_write_buffer;
    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  l2_address;
    logic         l2_read;
    logic         l2_write;
    logic [127:0] l2_wdata;
    logic         l2_mem_resp;
    logic [127:0] l2_rdata;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    l2_write_buffer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .l2_address(l2_address), .l2_read(l2_read), .l2_write(l2_write), .l2_wdata(l2_wdata),
        .l2_mem_resp(l2_mem_resp), .l2_rdata(l2_rdata),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic         is_read;
        logic [127:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [127:0] mem    [int];
    logic [127:0] shadow [int];
    int           wr_per_tag [int];

    bit           mem_hold = 1'b0;
    int           credits = 0;
    int           mem_lat = 1;
    int           wcnt = 0;
    bit           prev_rd = 1'b0;
    int           rd_starts = 0;
    int           drained = 0;
    int           last_pulse_cyc = 0;
    logic [15:0]  last_wr_addr = '0;
    logic [127:0] last_wr_data = '0;
    logic [15:0]  last_rd_addr = '0;
    int           issue_cyc = 0;
    int           resp_cyc = 0;

    function automatic logic [127:0] init_line(input int t);
        return {4{32'hC0DE0000 | 32'(t)}};
    endfunction

    function automatic logic [127:0] mem_line(input int t);
        if (mem.exists(t)) return mem[t];
        return init_line(t);
    endfunction

    function automatic logic [127:0] shadow_line(input int t);
        if (shadow.exists(t)) return shadow[t];
        return init_line(t);
    endfunction

    function automatic int tag_wr(input int t);
        if (wr_per_tag.exists(t)) return wr_per_tag[t];
        return 0;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic finish_up();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Memory responder: serves pmem requests after mem_lat cycles unless held (credits release one each).
    initial begin
        int t;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (pmem_read && !prev_rd) rd_starts++;
            prev_rd = pmem_read;
            if (reset || !(pmem_read || pmem_write)) begin
                wcnt = 0;
            end else begin
                checki("pmem_excl", int'(pmem_read & pmem_write), 0);
                checki("pmem_addr_lo", int'(pmem_address[3:0]), 0);
                if (!mem_hold || credits > 0) begin
                    if (wcnt >= mem_lat) begin
                        t = int'(pmem_address[15:4]);
                        if (pmem_read) begin
                            pmem_rdata   = mem_line(t);
                            last_rd_addr = pmem_address;
                        end else begin
                            mem[t]        = pmem_wdata;
                            wr_per_tag[t] = tag_wr(t) + 1;
                            drained++;
                            last_wr_addr  = pmem_address;
                            last_wr_data  = pmem_wdata;
                        end
                        pmem_resp      = 1'b1;
                        last_pulse_cyc = cyc;
                        wcnt           = 0;
                        if (mem_hold) credits--;
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: every response pops the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (l2_mem_resp === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checki("unexpected_resp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_read) check("rdata", l2_rdata, e.data);
                end
            end
        end
    end

    initial begin
        #1000000;
        checki("watchdog", 0, 1);
        finish_up();
    end

    task automatic issue(input bit rd, input logic [15:0] addr, input logic [127:0] wd);
        exp_t e;
        int   t;
        t          = int'(addr[15:4]);
        l2_address = addr;
        l2_read    = rd;
        l2_write   = !rd;
        l2_wdata   = wd;
        issue_cyc  = cyc;
        e.is_read  = rd;
        if (rd) begin
            e.data = shadow_line(t);
        end else begin
            e.data    = '0;
            shadow[t] = wd;
        end
        exp_q.push_back(e);
    endtask

    task automatic wait_resp(input int max, output bit ok, output int lat);
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (l2_mem_resp === 1'b1) begin
                ok       = 1'b1;
                resp_cyc = cyc;
                lat      = cyc - issue_cyc;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            l2_read  = 1'b0;
            l2_write = 1'b0;
        end
    endtask

    task automatic xfer(input bit rd, input logic [15:0] addr, input logic [127:0] wd,
                        input string name, input int exp_lat);
        bit ok;
        int lat;
        issue(rd, addr, wd);
        wait_resp(200, ok, lat);
        if (!ok) begin
            checki({"timeout_", name}, 0, 1);
            finish_up();
        end
        if (exp_lat >= 0) checki(name, lat, exp_lat);
    endtask

    task automatic settle();
        int quiet;
        quiet    = 0;
        mem_hold = 1'b0;
        credits  = 0;
        for (int i = 0; i < 400 && quiet < 4; i++) begin
            @(negedge clk);
            if (!pmem_read && !pmem_write) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) begin
            checki("settle", quiet, 4);
            finish_up();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit           ok;
        int           lat;
        int           d0;
        int           r0;
        int           w0;
        int           t;
        int           lo;
        logic [127:0] line_a;
        logic [127:0] line_e;

        reset = 1'b1; l2_address = '0; l2_read = 1'b0; l2_write = 1'b0; l2_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checki("rst_resp", int'(l2_mem_resp), 0);
        checki("rst_pread", int'(pmem_read), 0);
        checki("rst_pwrite", int'(pmem_write), 0);
        checki("rst_paddr", int'(pmem_address), 0);
        check("rst_rdata", l2_rdata, '0);
        check("rst_pwdata", pmem_wdata, '0);
        @(posedge clk);
        #1;

        // Single write then drain to idle memory.
        line_a = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
        d0 = drained;
        xfer(1'b0, 16'h1230, line_a, "t1_wr_lat", 1);
        settle();
        checki("t1_drains", drained - d0, 1);
        checki("t1_waddr", int'(last_wr_addr), 16'h1230);
        check("t1_wdata", last_wr_data, line_a);

        // Fill with memory stalled, fifth write stalls until one dequeue.
        mem_hold = 1'b1;
        credits  = 0;
        for (int i = 0; i < 4; i++)
            xfer(1'b0, 16'h1010 + 16'(i << 4), {4{32'h0B0B0000 + 32'(i)}}, "t2_wr_lat", 1);
        issue(1'b0, 16'h1050, {4{32'h0B0B0005}});
        wait_resp(10, ok, lat);
        checki("t2_full_stall", int'(ok), 0);
        credits = 1;
        wait_resp(30, ok, lat);
        checki("t2_released", int'(ok), 1);
        if (!ok) finish_up();
        checki("t2_deq_to_resp", resp_cyc - last_pulse_cyc, 2);
        settle();

        // Read hit on a buffered line while memory is stalled.
        mem_hold = 1'b1;
        r0 = rd_starts;
        xfer(1'b0, 16'h2000, {4{32'hBBBB2000}}, "t3_wr_lat", 1);
        xfer(1'b1, 16'h2004, '0, "t3_hit_lat", 1);
        checki("t3_no_pmem_read", rd_starts - r0, 0);
        settle();

        // Read miss on an empty buffer.
        mem_lat = 4;
        r0 = rd_starts;
        xfer(1'b1, 16'h4000, '0, "t4_miss_lat", mem_lat + 2);
        checki("t4_pmem_addr", int'(last_rd_addr), 16'h4000);
        checki("t4_resp_after_pmem", resp_cyc - last_pulse_cyc, 1);
        checki("t4_rd_count", rd_starts - r0, 1);
        mem_lat = 1;

        // Two writes to one tag during a memory stall.
        line_e = {4{32'hEEEE3000}};
        mem_hold = 1'b1;
        w0 = tag_wr(12'h300);
        xfer(1'b0, 16'h3000, {4{32'hDDDD3000}}, "t5_wr_d_lat", 1);
        xfer(1'b0, 16'h3008, line_e, "t5_wr_e_lat", 1);
        issue(1'b1, 16'h3000, '0);
        mem_hold = 1'b0;
        wait_resp(200, ok, lat);
        checki("t5_read_done", int'(ok), 1);
        if (!ok) finish_up();
        settle();
`ifdef L2_WB_COALESCE_EN
        checki("t5_tag_drains", tag_wr(12'h300) - w0, 1);
`else
        checki("t5_tag_drains", tag_wr(12'h300) - w0, 2);
`endif
        check("t5_mem_final", mem_line(12'h300), line_e);

        // Reset while a drain is in flight with three lines queued.
        mem_hold = 1'b1;
        d0 = drained;
        xfer(1'b0, 16'h5010, {4{32'h55550010}}, "t6_wr_lat", 1);
        xfer(1'b0, 16'h5020, {4{32'h55550020}}, "t6_wr_lat", 1);
        xfer(1'b0, 16'h5030, {4{32'h55550030}}, "t6_wr_lat", 1);
        checki("t6_draining", int'(pmem_write), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checki("t6_pwrite_after_rst", int'(pmem_write), 0);
        checki("t6_resp_after_rst", int'(l2_mem_resp), 0);
        checki("t6_paddr_after_rst", int'(pmem_address), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        shadow   = mem;
        mem_hold = 1'b0;
        r0 = rd_starts;
        xfer(1'b1, 16'h5020, '0, "t6_read_miss_lat", mem_lat + 2);
        checki("t6_read_missed", rd_starts - r0, 1);
        settle();
        checki("t6_no_drain", drained - d0, 0);

        // Randomised traffic over a small tag pool.
        for (int n = 0; n < 200; n++) begin
            mem_lat = int'($urandom_range(0, 3));
            t  = int'($urandom_range(0, 7));
            lo = int'($urandom_range(0, 15));
            xfer(1'($urandom_range(0, 1)), 16'h7000 | 16'(t << 4) | 16'(lo),
                 {$urandom(), $urandom(), $urandom(), $urandom()}, "rnd", -1);
        end
        settle();
        for (int i = 0; i < 8; i++)
            check("rnd_mem_final", mem_line(12'h700 + i), shadow_line(12'h700 + i));
        checki("sb_empty", exp_q.size(), 0);

        finish_up();
    end

endmodule
